// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM PIO: register word addresses and edge-type codes.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain, previous-value history flop and per-bit edge detector.
module pio_sync_edge
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_async,
    output logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] edge_vec
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  hist_q, hist_d;

    // Shift the asynchronous lines through the chain; history lags the last stage by one cycle.
    always_comb begin
        sync_d[0] = in_async;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and history registers, cleared to 0 so low inputs at reset release look quiet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign data_in = sync_q[SYNC_STAGES-1];

    // Edge vector selected by the elaboration-time edge type.
    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALLING: edge_vec = ~data_in & hist_q;
            EDGE_ANY:     edge_vec = data_in ^ hist_q;
            default:      edge_vec = data_in & ~hist_q;
        endcase
    end

endmodule

// File: rtl/avalon_pio_ex.sv
// Avalon-MM zero-wait-state PIO: output register with atomic set/clear, synchronised
// input port, write-1-to-clear edge capture and a maskable level interrupt.
module avalon_pio_ex
    import avalon_pio_pkg::*;
#(
    parameter int                   OUT_WIDTH   = 32,
    parameter int                   IN_WIDTH    = 32,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET   = '0,
    parameter int                   EDGE_TYPE   = EDGE_RISING,
    parameter int                   SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [IN_WIDTH-1:0]  in_port,
    output logic [OUT_WIDTH-1:0] out_port,
    output logic                 irq
);

    logic                 we;
    logic [OUT_WIDTH-1:0] wd_out;
    logic [IN_WIDTH-1:0]  wd_in;

    logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic [IN_WIDTH-1:0]  irq_mask_q, irq_mask_d;
    logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_d;
    logic [IN_WIDTH-1:0]  data_in;
    logic [IN_WIDTH-1:0]  edge_vec;
    logic [IN_WIDTH-1:0]  cap_clr;

    assign we     = chipselect & ~write_n;
    assign wd_out = writedata[OUT_WIDTH-1:0];
    assign wd_in  = writedata[IN_WIDTH-1:0];

    pio_sync_edge #(
        .WIDTH       (IN_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_async (in_port),
        .data_in  (data_in),
        .edge_vec (edge_vec)
    );

    // Next-state for the writable registers; a fresh edge beats a same-cycle clear.
    always_comb begin
        data_out_d = data_out_q;
        irq_mask_d = irq_mask_q;
        cap_clr    = '0;
        if (we) begin
            case (address)
                ADDR_DATA_OUT: data_out_d = wd_out;
                ADDR_IRQ_MASK: irq_mask_d = wd_in;
                ADDR_EDGE_CAP: cap_clr    = wd_in;
                ADDR_OUTSET:   data_out_d = data_out_q | wd_out;
                ADDR_OUTCLEAR: data_out_d = data_out_q & ~wd_out;
                default:       ;
            endcase
        end
        edge_cap_d = (edge_cap_q & ~cap_clr) | edge_vec;
    end

    // Register file state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= OUT_RESET;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
        end else begin
            data_out_q <= data_out_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
        end
    end

    // Zero-wait read mux, independent of chipselect; write-only and reserved words read 0.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA_OUT: readdata[OUT_WIDTH-1:0] = data_out_q;
            ADDR_DATA_IN:  readdata[IN_WIDTH-1:0]  = data_in;
            ADDR_IRQ_MASK: readdata[IN_WIDTH-1:0]  = irq_mask_q;
            ADDR_EDGE_CAP: readdata[IN_WIDTH-1:0]  = edge_cap_q;
            default:       readdata = '0;
        endcase
    end

    assign out_port = data_out_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_avalon_pio_ex.sv
// Directed bench: two PIO instances (rising-edge and any-edge) on a shared bus.
module tb_avalon_pio_ex;

    logic        clk = 1'b0;
    logic        reset_n_r, reset_n_a;
    logic [2:0]  address;
    logic        cs_r, cs_a, write_n;
    logic [31:0] writedata;
    logic [31:0] readdata_r, readdata_a;
    logic [7:0]  in_port;
    logic [31:0] out_port_r, out_port_a;
    logic        irq_r, irq_a;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_pio_ex #(
        .OUT_WIDTH(32), .IN_WIDTH(8), .OUT_RESET(32'h0000_00A5),
        .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) dut_r (
        .clk(clk), .reset_n(reset_n_r), .address(address), .chipselect(cs_r),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_r),
        .in_port(in_port), .out_port(out_port_r), .irq(irq_r)
    );

    avalon_pio_ex #(
        .OUT_WIDTH(32), .IN_WIDTH(8), .OUT_RESET(32'h0000_00A5),
        .EDGE_TYPE(2), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .reset_n(reset_n_a), .address(address), .chipselect(cs_a),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
        .in_port(in_port), .out_port(out_port_a), .irq(irq_a)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input bit sel_a, input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs_r      = !sel_a;
        cs_a      = sel_a;
        @(negedge clk);
        write_n   = 1'b1;
        cs_r      = 1'b0;
        cs_a      = 1'b0;
    endtask

    task automatic rd(input bit sel_a, input logic [2:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        chk(tag, sel_a ? readdata_a : readdata_r, exp);
    endtask

    initial begin
        reset_n_r = 1'b0; reset_n_a = 1'b0;
        address = '0; cs_r = 0; cs_a = 0; write_n = 1; writedata = '0; in_port = '0;
        cyc(2);
        // reset state
        chk("rst_out_port", out_port_r, 32'h0000_00A5);
        rd(0, 3'd0, 32'h0000_00A5, "rst_data_out");
        rd(0, 3'd2, 32'h0, "rst_irq_mask");
        rd(0, 3'd3, 32'h0, "rst_edge_cap");
        chk("rst_irq", {31'b0, irq_r}, 32'h0);
        reset_n_r = 1'b1; reset_n_a = 1'b1;
        cyc(2);

        // output register with set/clear
        wr(0, 3'd0, 32'hF0F0_0000);
        chk("out_write", out_port_r, 32'hF0F0_0000);
        wr(0, 3'd4, 32'h0000_000F);
        chk("out_set", out_port_r, 32'hF0F0_000F);
        wr(0, 3'd5, 32'h1000_0000);
        chk("out_clear", out_port_r, 32'hE0F0_000F);
        rd(0, 3'd0, 32'hE0F0_000F, "rd_data_out");
        rd(0, 3'd4, 32'h0, "rd_outset_zero");
        rd(0, 3'd5, 32'h0, "rd_outclear_zero");
        wr(0, 3'd6, 32'hFFFF_FFFF);
        rd(0, 3'd6, 32'h0, "rd_reserved_zero");
        chk("reserved_no_effect", out_port_r, 32'hE0F0_000F);

        // rising edge latency, mask bit 0
        wr(0, 3'd2, 32'hFFFF_FF01);
        rd(0, 3'd2, 32'h0000_0001, "irq_mask_trunc");
        @(negedge clk);
        in_port = 8'h01;            // before edge k
        @(negedge clk);             // after k
        rd(0, 3'd1, 32'h0, "din_after_k");
        @(negedge clk);             // after k+1
        rd(0, 3'd1, 32'h1, "din_after_k1");
        rd(0, 3'd3, 32'h0, "cap_after_k1");
        chk("irq_after_k1", {31'b0, irq_r}, 32'h0);
        @(negedge clk);             // after k+2
        rd(0, 3'd3, 32'h1, "cap_after_k2");
        chk("irq_after_k2", {31'b0, irq_r}, 32'h1);
        wr(0, 3'd3, 32'h1);
        rd(0, 3'd3, 32'h0, "cap_w1c");
        chk("irq_w1c", {31'b0, irq_r}, 32'h0);
        in_port = 8'h00;            // falling edge: ignored by rising detector
        cyc(4);
        rd(0, 3'd3, 32'h0, "cap_falling_ignored");
        chk("irq_falling_ignored", {31'b0, irq_r}, 32'h0);

        // capture 0x3, mask 0x2
        in_port = 8'h03;
        cyc(4);
        rd(0, 3'd3, 32'h3, "cap_two_bits");
        wr(0, 3'd2, 32'h2);
        chk("irq_mask2", {31'b0, irq_r}, 32'h1);
        wr(0, 3'd3, 32'h2);
        rd(0, 3'd3, 32'h1, "cap_clear_bit1");
        chk("irq_after_clear_bit1", {31'b0, irq_r}, 32'h0);
        wr(0, 3'd3, 32'h1);
        rd(0, 3'd3, 32'h0, "cap_clear_bit0");

        // clear collides with a fresh rising edge on bit 0
        in_port = 8'h02;
        cyc(4);
        in_port = 8'h03;            // before edge k
        cyc(2);                     // after k+1: edge vector live for edge k+2
        wr(0, 3'd3, 32'h1);         // clear lands on edge k+2
        rd(0, 3'd3, 32'h1, "cap_edge_beats_clear");

        // any-edge instance: start clean, then falling edges must be captured
        wr(1, 3'd3, 32'hFFFF_FFFF);
        rd(1, 3'd3, 32'h0, "any_cap_cleared");
        in_port = 8'h00;
        cyc(4);
        rd(1, 3'd3, 32'h3, "any_cap_falling");
        rd(0, 3'd3, 32'h1, "rise_cap_no_falling");
        wr(1, 3'd2, 32'h3);
        chk("any_irq", {31'b0, irq_a}, 32'h1);
        wr(1, 3'd0, 32'h1234_5678);
        chk("any_out_write", out_port_a, 32'h1234_5678);

        // asynchronous reset mid-cycle
        #2;
        reset_n_a = 1'b0;
        #1;
        chk("arst_out_port", out_port_a, 32'h0000_00A5);
        chk("arst_irq", {31'b0, irq_a}, 32'h0);
        rd(1, 3'd3, 32'h0, "arst_edge_cap");
        rd(1, 3'd2, 32'h0, "arst_irq_mask");
        rd(1, 3'd1, 32'h0, "arst_data_in");
        cyc(2);
        reset_n_a = 1'b1;
        cyc(4);
        rd(1, 3'd3, 32'h0, "post_rst_no_capture");
        chk("post_rst_out_port", out_port_a, 32'h0000_00A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
